// File: rtl/imm_encoder.sv
// imm_encoder: iterative encoder for ARM data-processing 32-bit immediates.
// Searches rotations r = 0..15 (one per cycle) for the smallest r such that
// value == ROR({24'b0, imm8}, 2*r), and reports {rotate_imm, imm8}.
// Optional build macro IMM_ENC_MVN_EN: on a first-pass miss, a second pass
// searches ~value and flags a hit with use_mvn.
module imm_encoder #(
  parameter int unsigned WORD_WIDTH            = 32,
  parameter int unsigned SHIFTER_OPERAND_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            value,
  output logic                             busy,
  output logic                             done,
  output logic                             found,
  output logic [3:0]                       rotate_imm,
  output logic [7:0]                       imm8,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand,
  output logic                             use_mvn
);

  localparam int unsigned ROT_W = 4;
  localparam int unsigned IMM_W = 8;
  localparam int unsigned SH_W  = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [ROT_W-1:0] R_LAST = 4'd15;

  logic [1:0]                       state, state_d;
  logic [ROT_W-1:0]                 r, r_d;
  logic [WORD_WIDTH-1:0]            val_q, val_d;
  logic                             busy_d, done_d, found_d;
  logic [ROT_W-1:0]                 rot_d;
  logic [IMM_W-1:0]                 imm_d;
  logic [SHIFTER_OPERAND_WIDTH-1:0] so_d;
  logic                             mvn_d;

  logic [WORD_WIDTH-1:0]            search_word;
  logic [SH_W-1:0]                  sh;
  logic [WORD_WIDTH-1:0]            rot_word;
  logic                             hit;

`ifdef IMM_ENC_MVN_EN
  logic                             pass, pass_d;
  logic                             mvn_q;
`endif

  // Word under test for the current pass (value, or its complement in pass 2)
  always_comb begin
`ifdef IMM_ENC_MVN_EN
    search_word = pass ? ~val_q : val_q;
`else
    search_word = val_q;
`endif
  end

  // Rotate left by 2*r; a shift of WORD_WIDTH yields zero, so r=0 is clean
  always_comb begin
    sh       = SH_W'({r, 1'b0});
    rot_word = (search_word << sh) | (search_word >> (SH_W'(WORD_WIDTH) - sh));
    hit      = (rot_word[WORD_WIDTH-1:IMM_W] == '0);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    r_d     = r;
    val_d   = val_q;
    busy_d  = busy;
    done_d  = 1'b0;
    found_d = found;
    rot_d   = rotate_imm;
    imm_d   = imm8;
`ifdef IMM_ENC_MVN_EN
    pass_d  = pass;
    mvn_d   = mvn_q;
`else
    mvn_d   = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (start) begin
          val_d   = value;
          r_d     = '0;
          found_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SEARCH;
`ifdef IMM_ENC_MVN_EN
          pass_d  = 1'b0;
`endif
        end
      end

      ST_SEARCH: begin
        if (hit) begin
          // First hit is the smallest rotation
          found_d = 1'b1;
          rot_d   = r;
          imm_d   = rot_word[IMM_W-1:0];
`ifdef IMM_ENC_MVN_EN
          mvn_d   = pass;
`endif
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (r == R_LAST) begin
`ifdef IMM_ENC_MVN_EN
          if (!pass) begin
            // First pass exhausted: retry on the complement
            pass_d = 1'b1;
            r_d    = '0;
          end else begin
            found_d = 1'b0;
            rot_d   = '0;
            imm_d   = '0;
            mvn_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
`else
          found_d = 1'b0;
          rot_d   = '0;
          imm_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
          r_d = r + ROT_W'(1);
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    so_d = SHIFTER_OPERAND_WIDTH'({rot_d, imm_d});
  end

  // State and registered outputs; synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      r               <= '0;
      val_q           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      found           <= 1'b0;
      rotate_imm      <= '0;
      imm8            <= '0;
      shifter_operand <= '0;
    end else begin
      state           <= state_d;
      r               <= r_d;
      val_q           <= val_d;
      busy            <= busy_d;
      done            <= done_d;
      found           <= found_d;
      rotate_imm      <= rot_d;
      imm8            <= imm_d;
      shifter_operand <= so_d;
    end
  end

`ifdef IMM_ENC_MVN_EN
  // Second-pass tracking and MVN flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pass  <= 1'b0;
      mvn_q <= 1'b0;
    end else begin
      pass  <= pass_d;
      mvn_q <= mvn_d;
    end
  end

  assign use_mvn = mvn_q;
`else
  // MVN form not built: flag is constant and the next value is unused
  logic unused_mvn;
  assign unused_mvn = mvn_d;
  assign use_mvn    = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table, hand-written reset/abort
// sequence and randomised round-trip values, checked through a scoreboard.
module tb_imm_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [3:0]  rotate_imm;
  logic [7:0]  imm8;
  logic [11:0] shifter_operand;
  logic        use_mvn;

  imm_encoder dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .value           (value),
    .busy            (busy),
    .done            (done),
    .found           (found),
    .rotate_imm      (rotate_imm),
    .imm8            (imm8),
    .shifter_operand (shifter_operand),
    .use_mvn         (use_mvn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic        found;
    logic [3:0]  rot;
    logic [7:0]  imm8;
    logic        mvn;
    int          lat;
    bit          roundtrip;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int amt);
    logic [63:0] d;
    d = {x, x} >> (amt % 32);
    return d[31:0];
  endfunction

  // Reference: smallest r whose candidate byte reproduces v when decoded
  task automatic model(input logic [31:0] v, output logic f, output logic [3:0] rr,
                       output logic [7:0] ib);
    logic [31:0] cand;
    f = 1'b0; rr = 4'd0; ib = 8'd0;
    for (int k = 0; k < 16; k++) begin
      cand = ror32(v, 32 - 2 * k);
      if (!f && ror32({24'd0, cand[7:0]}, 2 * k) == v) begin
        f = 1'b1; rr = 4'(k); ib = cand[7:0];
      end
    end
  endtask

  // Launch one encode, then wait (bounded) for done and score the result
  task automatic run_op(input logic [31:0] v, input logic ef, input logic [3:0] er,
                        input logic [7:0] ei, input logic em, input int lat, input bit rt);
    exp_t e;
    exp_t got;
    int   n;
    step();
    start = 1'b1;
    value = v;
    e = '{value: v, found: ef, rot: er, imm8: ei, mvn: em, lat: lat, roundtrip: rt,
          start_cyc: cyc};
    sb.push_back(e);
    step();
    start = 1'b0;
    value = $urandom;
    chk("found_cleared_on_start", {31'd0, found}, 32'd0);
    chk("busy_in_search", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no done expected done for value 0x%0h", v);
      sb.delete();
    end else if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
    end else begin
      got = sb.pop_front();
      chk("latency", 32'(cyc - got.start_cyc), 32'(got.lat));
      chk("found", {31'd0, found}, {31'd0, got.found});
      chk("rotate_imm", {28'd0, rotate_imm}, {28'd0, got.rot});
      chk("imm8", {24'd0, imm8}, {24'd0, got.imm8});
      chk("shifter_operand", {20'd0, shifter_operand}, {20'd0, got.rot, got.imm8});
      chk("use_mvn", {31'd0, use_mvn}, {31'd0, got.mvn});
      if (got.roundtrip)
        chk("roundtrip", ror32({24'd0, imm8}, 2 * int'(rotate_imm)), got.value);
      step();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      chk("result_held", {20'd0, shifter_operand}, {20'd0, got.rot, got.imm8});
    end
  endtask

  typedef struct {
    logic [31:0] value;
    logic        found;
    logic [3:0]  rot;
    logic [7:0]  imm8;
    logic        mvn;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          s0;
    int          n;
    logic [31:0] rv;
    logic        mf;
    logic [3:0]  mr;
    logic [7:0]  mi;
    logic [7:0]  ri;
    int          rr;

    vecs.push_back('{32'h0000_00FF, 1'b1, 4'd0,  8'hFF, 1'b0, 2});
    vecs.push_back('{32'hF000_000F, 1'b1, 4'd2,  8'hFF, 1'b0, 4});
    vecs.push_back('{32'h0000_03FC, 1'b1, 4'd15, 8'hFF, 1'b0, 17});
    vecs.push_back('{32'h0000_0000, 1'b1, 4'd0,  8'h00, 1'b0, 2});
    vecs.push_back('{32'hFF00_0000, 1'b1, 4'd4,  8'hFF, 1'b0, 6});
    vecs.push_back('{32'h8000_0001, 1'b1, 4'd1,  8'h06, 1'b0, 3});
`ifdef IMM_ENC_MVN_EN
    vecs.push_back('{32'h0000_0101, 1'b0, 4'd0,  8'h00, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FF00, 1'b1, 4'd0,  8'hFF, 1'b1, 18});
`else
    vecs.push_back('{32'h0000_0101, 1'b0, 4'd0,  8'h00, 1'b0, 17});
    vecs.push_back('{32'hFFFF_FF00, 1'b0, 4'd0,  8'h00, 1'b0, 17});
`endif

    rst   = 1'b1;
    start = 1'b0;
    value = 32'hDEAD_BEEF;
    step();
    step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_found", {31'd0, found}, 32'd0);
    chk("reset_shifter_operand", {20'd0, shifter_operand}, 32'd0);
    chk("reset_use_mvn", {31'd0, use_mvn}, 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i])
      run_op(vecs[i].value, vecs[i].found, vecs[i].rot, vecs[i].imm8, vecs[i].mvn,
             vecs[i].lat, vecs[i].found && !vecs[i].mvn);

    // Abort: a long search, a start while busy, then rst mid-search
    step();
    start = 1'b1;
    value = 32'h0000_0101;
    s0 = cyc;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    value = 32'h0000_00FF;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_cycle", 32'(cyc - s0), 32'd6);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_found", {31'd0, found}, 32'd0);
    chk("abort_rotate_imm", {28'd0, rotate_imm}, 32'd0);
    chk("abort_imm8", {24'd0, imm8}, 32'd0);
    chk("abort_shifter_operand", {20'd0, shifter_operand}, 32'd0);
    chk("abort_use_mvn", {31'd0, use_mvn}, 32'd0);
    run_op(32'h0000_0000, 1'b1, 4'd0, 8'h00, 1'b0, 2, 1'b1);
    // No stray done from the aborted or ignored requests
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) n++;
    end
    chk("no_stray_done", 32'(n), 32'd0);

    // Randomised round trips: values built as ROR(imm8, 2*r)
    for (int t = 0; t < 1000; t++) begin
      ri = 8'($urandom_range(255, 0));
      rr = int'($urandom_range(15, 0));
      rv = ror32({24'd0, ri}, 2 * rr);
      model(rv, mf, mr, mi);
      run_op(rv, mf, mr, mi, 1'b0, int'(mr) + 2, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
